// File: rtl/mips_pc_sequencer_pkg.sv
// Shared types for the PC sequencer: PC action encoding, FSM states and target helpers.
`default_nettype none

package mips_pc_sequencer_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_INC    = 2'd1,
    ACT_JUMP   = 2'd2,
    ACT_BRANCH = 2'd3
  } pc_action_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HELD  = 2'd2
  } seq_state_e;

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Jump keeps the 256 MB region of the delay-slot PC, not of the jump itself.
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] jidx);
    logic [31:0] pc_plus4;
    pc_plus4 = pc + 32'd4;
    return {pc_plus4[31:28], jidx, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_pc_sequencer_if.sv
// EX-resolved PC action, instruction-memory handshake and IF/ID delivery bundle.
`default_nettype none

interface mips_pc_sequencer_if;
  import mips_pc_sequencer_pkg::*;

  pc_action_e  action;
  logic [31:0] ex_pc;
  logic [15:0] ex_imm;
  logic [25:0] ex_jtarget;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        fetch_valid;
  logic [31:0] fetch_word;
  logic [31:0] fetch_pc;
  logic        flush;

  modport master (
    input  action, ex_pc, ex_imm, ex_jtarget, stall, imem_ready, imem_data,
    output imem_req, imem_addr, fetch_valid, fetch_word, fetch_pc, flush
  );

  modport slave (
    output action, ex_pc, ex_imm, ex_jtarget, stall, imem_ready, imem_data,
    input  imem_req, imem_addr, fetch_valid, fetch_word, fetch_pc, flush
  );

endinterface

`default_nettype wire

// File: rtl/mips_pc_target.sv
// Combinational next-PC selection: sequential, branch or jump target plus redirect flag.
`default_nettype none

module mips_pc_target
  import mips_pc_sequencer_pkg::*;
(
  input  pc_action_e  action,
  input  logic [31:0] pc,
  input  logic [31:0] ex_pc,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_jtarget,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);

  assign seq_pc = pc + 32'd4;

  always_comb begin
    redirect = 1'b0;
    target   = seq_pc;
    case (action)
      ACT_JUMP: begin
        redirect = 1'b1;
        target   = jump_target(ex_pc, ex_jtarget);
      end
      ACT_BRANCH: begin
        redirect = 1'b1;
        target   = branch_target(ex_pc, ex_imm);
      end
      default: begin
        redirect = 1'b0;
        target   = seq_pc;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_pc_sequencer.sv
// Architectural PC owner: issues fetch requests, applies EX redirects with a flush pulse,
// and delivers fetched words to IF/ID through a one-entry stall buffer.
`default_nettype none

module mips_pc_sequencer
  import mips_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mips_pc_sequencer_if.master  bus
);

  seq_state_e  state;
  logic [31:0] pc;
  logic        req;
  logic        valid;
  logic [31:0] word;
  logic [31:0] word_pc;
  logic        flush;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_pc;

  mips_pc_target u_target (
    .action     (bus.action),
    .pc         (pc),
    .ex_pc      (bus.ex_pc),
    .ex_imm     (bus.ex_imm),
    .ex_jtarget (bus.ex_jtarget),
    .redirect   (redirect),
    .target     (target),
    .seq_pc     (seq_pc)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.fetch_valid = valid;
  assign bus.fetch_word  = word;
  assign bus.fetch_pc    = word_pc;
  assign bus.flush       = flush;

  // The output registers double as the one-entry stall buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_BOOT;
      pc      <= RESET_PC;
      req     <= 1'b0;
      valid   <= 1'b0;
      word    <= 32'd0;
      word_pc <= 32'd0;
      flush   <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
          req   <= 1'b1;
        end
        ST_FETCH: begin
          if (redirect) begin
            pc    <= target;
            flush <= 1'b1;
            valid <= 1'b0;
          end else if (bus.imem_ready) begin
            word    <= bus.imem_data;
            word_pc <= pc;
            valid   <= 1'b1;
            pc      <= seq_pc;
            if (bus.stall) begin
              state <= ST_HELD;
              req   <= 1'b0;
            end
          end else if (!bus.stall) begin
            valid <= 1'b0;
          end
        end
        ST_HELD: begin
          if (redirect) begin
            pc    <= target;
            flush <= 1'b1;
            valid <= 1'b0;
            state <= ST_FETCH;
            req   <= 1'b1;
          end else if (!bus.stall) begin
            valid <= 1'b0;
            state <= ST_FETCH;
            req   <= 1'b1;
          end
        end
        default: begin
          state <= ST_BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_pc_sequencer.sv
// Scoreboard bench for mips_pc_sequencer: a cycle model predicts outputs per driven cycle.
`default_nettype none

module tb_mips_pc_sequencer;
  import mips_pc_sequencer_pkg::*;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] word;
    logic [31:0] fpc;
    logic        flush;
  } exp_t;

  logic clock;
  logic reset_n;
  mips_pc_sequencer_if bus ();

  mips_pc_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  seq_state_e  m_state;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_word;
  logic [31:0] m_fpc;
  logic        m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_target(input pc_action_e act, input logic [31:0] epc,
                                             input logic [15:0] imm, input logic [25:0] jt);
    logic signed [31:0] off;
    logic [31:0] nxt;
    off = {{16{imm[15]}}, imm};
    nxt = epc + 32'd4;
    if (act == ACT_BRANCH) return nxt + 32'(off * 4);
    return {nxt[31:28], jt, 2'b00};
  endfunction

  task automatic model_reset();
    m_state = ST_BOOT; m_pc = 32'h0; m_valid = 1'b0;
    m_word = 32'h0; m_fpc = 32'h0; m_flush = 1'b0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.req = (m_state == ST_FETCH); e.addr = m_pc; e.valid = m_valid;
    e.word = m_word; e.fpc = m_fpc; e.flush = m_flush;
    return e;
  endfunction

  task automatic model_advance(input logic rdy, input logic stl, input pc_action_e act,
                               input logic [31:0] epc, input logic [15:0] imm, input logic [25:0] jt);
    logic redir;
    redir = (act == ACT_JUMP) || (act == ACT_BRANCH);
    m_flush = 1'b0;
    case (m_state)
      ST_BOOT: m_state = ST_FETCH;
      ST_FETCH: begin
        if (redir) begin
          m_pc = ref_target(act, epc, imm, jt); m_flush = 1'b1; m_valid = 1'b0;
        end else if (rdy) begin
          m_valid = 1'b1; m_word = mem_word(m_pc); m_fpc = m_pc; m_pc = m_pc + 32'd4;
          if (stl) m_state = ST_HELD;
        end else if (!stl) m_valid = 1'b0;
      end
      default: begin
        if (redir) begin
          m_pc = ref_target(act, epc, imm, jt); m_flush = 1'b1; m_valid = 1'b0; m_state = ST_FETCH;
        end else if (!stl) begin
          m_valid = 1'b0; m_state = ST_FETCH;
        end
      end
    endcase
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("imem_req", {31'd0, bus.imem_req}, {31'd0, e.req});
    check("imem_addr", bus.imem_addr, e.addr);
    check("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, e.valid});
    check("flush", {31'd0, bus.flush}, {31'd0, e.flush});
    if (e.valid) begin
      check("fetch_word", bus.fetch_word, e.word);
      check("fetch_pc", bus.fetch_pc, e.fpc);
    end
  endtask

  task automatic step(input logic rdy, input logic stl, input pc_action_e act,
                      input logic [31:0] epc, input logic [15:0] imm, input logic [25:0] jt);
    bus.imem_ready = rdy;
    bus.stall      = stl;
    bus.action     = act;
    bus.ex_pc      = epc;
    bus.ex_imm     = imm;
    bus.ex_jtarget = jt;
    bus.imem_data  = mem_word(m_pc);
    model_advance(rdy, stl, act, epc, imm, jt);
    sb.push_back(model_outputs());
    @(posedge clock);
    #1;
    compare_next();
  endtask

  task automatic seq(input logic rdy, input logic stl);
    step(rdy, stl, ACT_NONE, 32'h0, 16'h0, 26'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.action = ACT_NONE; bus.ex_pc = 32'h0; bus.ex_imm = 16'h0; bus.ex_jtarget = 26'h0;
    bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.imem_data = 32'h0;
    model_reset();
    #1;
    sb.push_back(model_outputs());
    compare_next();
    check("reset_fetch_word", bus.fetch_word, 32'h0);
    check("reset_fetch_pc", bus.fetch_pc, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    sb.push_back(model_outputs());
    compare_next();
    reset_n = 1'b1;

    // Boot, then back-to-back words from 0x0
    repeat (5) seq(1'b1, 1'b0);
    step(1'b1, 1'b0, ACT_INC, 32'h8, 16'h0, 26'h0);

    // Branch backwards, word in flight discarded
    step(1'b1, 1'b0, ACT_BRANCH, 32'h0000_0100, 16'hFFFE, 26'h0);
    check("branch_addr", bus.imem_addr, 32'h0000_00FC);
    seq(1'b1, 1'b0);

    // Jump across a region boundary of the delay slot
    step(1'b1, 1'b0, ACT_JUMP, 32'h3FFF_FFFC, 16'h0, 26'h000_0040);
    check("jump_addr", bus.imem_addr, 32'h4000_0100);
    seq(1'b1, 1'b0);

    // Stall after the word at 0x20 returns
    step(1'b0, 1'b0, ACT_JUMP, 32'h0, 16'h0, 26'h000_0008);
    step(1'b1, 1'b1, ACT_NONE, 32'h0, 16'h0, 26'h0);
    check("held_fetch_pc", bus.fetch_pc, 32'h0000_0020);
    seq(1'b1, 1'b1);
    seq(1'b0, 1'b1);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    check("resume_fetch_pc", bus.fetch_pc, 32'h0000_0024);

    // Redirect while HELD with stall still high
    seq(1'b1, 1'b1);
    step(1'b1, 1'b1, ACT_BRANCH, 32'h0000_0200, 16'h0010, 26'h0);
    check("held_redirect_addr", bus.imem_addr, 32'h0000_0244);
    seq(1'b1, 1'b0);

    // Two redirects back to back
    step(1'b1, 1'b0, ACT_JUMP, 32'h0000_1000, 16'h0, 26'h000_0100);
    step(1'b1, 1'b0, ACT_BRANCH, 32'h0000_2000, 16'h0001, 26'h0);
    check("second_redirect_addr", bus.imem_addr, 32'h0000_2008);
    seq(1'b1, 1'b0);

    // Sequential wrap from the top of the address space
    step(1'b1, 1'b0, ACT_JUMP, 32'hF000_0000, 16'h0, 26'h3FF_FFFF);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);
    check("wrap_fetch_pc", bus.fetch_pc, 32'h0000_0000);

    // Reset asserted mid-request, stale ready and redirect ignored in BOOT
    bus.imem_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    sb.push_back(model_outputs());
    compare_next();
    @(posedge clock);
    #1;
    sb.push_back(model_outputs());
    compare_next();
    reset_n = 1'b1;
    step(1'b1, 1'b0, ACT_JUMP, 32'h0000_0500, 16'h0, 26'h000_0777);
    seq(1'b1, 1'b0);
    seq(1'b1, 1'b0);

    // Randomised mix of ready, stall and redirects
    for (int i = 0; i < 60; i++) begin
      pc_action_e act;
      act = ($urandom_range(0, 5) == 0) ? pc_action_e'($urandom_range(2, 3))
                                        : pc_action_e'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), act,
           $urandom, 16'($urandom), 26'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
